// File: rtl/tlul_host_adapter_pkg.sv
// Shared TL-UL definitions for the host adapter: bus widths, opcodes and
// the bit offsets of the flattened h2d/d2h vectors.
package tlul_host_adapter_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_DBW = 4;
  localparam int TL_SZW = 2;
  localparam int TL_DUW = 16;

  localparam int H2D_W = 102;
  localparam int D2H_W = 68;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // h2d (A channel + d_ready) field offsets
  localparam int H2D_A_VALID    = 101;
  localparam int H2D_OPCODE_LSB = 98;
  localparam int H2D_PARAM_LSB  = 95;
  localparam int H2D_SIZE_LSB   = 93;
  localparam int H2D_SOURCE_LSB = 85;
  localparam int H2D_ADDR_LSB   = 53;
  localparam int H2D_MASK_LSB   = 49;
  localparam int H2D_DATA_LSB   = 17;
  localparam int H2D_USER_LSB   = 1;
  localparam int H2D_D_READY    = 0;

  // d2h (D channel + a_ready) field offsets
  localparam int D2H_D_VALID    = 67;
  localparam int D2H_OPCODE_LSB = 64;
  localparam int D2H_PARAM_LSB  = 61;
  localparam int D2H_SIZE_LSB   = 59;
  localparam int D2H_SOURCE_LSB = 51;
  localparam int D2H_SINK       = 50;
  localparam int D2H_DATA_LSB   = 18;
  localparam int D2H_USER_LSB   = 2;
  localparam int D2H_ERROR      = 1;
  localparam int D2H_A_READY    = 0;

  // ID width: a single outstanding slot still needs one bit of index.
  function automatic int idx_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/tlul_host_adapter_if.sv
// Core-side req/gnt/rvalid memory port bundled for the TL-UL host adapter.
interface tlul_host_adapter_if;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, we_i, be_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, be_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/tlul_host_adapter_prim_id_fifo.sv
// Circular FIFO of in-flight source indices, in request order; the head is
// the ID the next D response must carry.
module prim_id_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  parameter int unsigned CntW  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (Depth <= 2) ? 1 : $clog2(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_r [Depth];
  logic [PtrW-1:0]  wr_ptr_r;
  logic [PtrW-1:0]  rd_ptr_r;
  logic [CntW-1:0]  count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == DepthCnt);
  assign empty     = (count_r == {CntW{1'b0}});
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
      wr_ptr_r <= {PtrW{1'b0}};
      rd_ptr_r <= {PtrW{1'b0}};
      count_r  <= {CntW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r <= (wr_ptr_r == LastPtr) ? {PtrW{1'b0}} : wr_ptr_r + PtrW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= (rd_ptr_r == LastPtr) ? {PtrW{1'b0}} : rd_ptr_r + PtrW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_adapter.sv
// Bridge from a core req/gnt/rvalid port to a flattened TL-UL host port with
// up to MaxReqs outstanding requests and in-order response checking.
module tlul_host_adapter
  import tlul_host_adapter_pkg::*;
#(
  parameter int unsigned MaxReqs    = 2,
  parameter logic [7:0]  SourceBase = 8'h00
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tlul_host_adapter_if.slave   core,
  output logic [H2D_W-1:0]     tl_o,
  input  logic [D2H_W-1:0]     tl_i,
  output logic [4:0]           outstanding_o,
  output logic                 proto_err_o
);

  localparam int unsigned IdxW = idx_width(MaxReqs);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxReqs - 1);

  logic              full_s;
  logic              empty_s;
  logic              a_valid_s;
  logic              a_hs_s;
  logic              d_valid_s;
  logic              pop_s;
  logic              mismatch_s;
  logic              unexpected_s;
  logic [IdxW-1:0]   idx_r;
  logic [IdxW-1:0]   head_s;
  logic [TL_AIW-1:0] a_source_s;
  logic [TL_AIW-1:0] head_source_s;
  logic [TL_AIW-1:0] d_source_s;
  logic [4:0]        count_s;
  logic              proto_err_r;
  tl_a_op_e          a_opcode_s;
  logic              unused_d2h_s;

  assign a_valid_s     = core.req_i & ~full_s;
  assign a_hs_s        = a_valid_s & tl_i[D2H_A_READY];
  assign d_valid_s     = tl_i[D2H_D_VALID];
  assign d_source_s    = tl_i[D2H_SOURCE_LSB +: TL_AIW];
  assign pop_s         = d_valid_s & ~empty_s;
  assign unexpected_s  = d_valid_s & empty_s;
  assign a_source_s    = SourceBase | TL_AIW'(idx_r);
  assign head_source_s = SourceBase | TL_AIW'(head_s);
  assign mismatch_s    = pop_s & (d_source_s != head_source_s);
  assign outstanding_o = count_s;
  assign proto_err_o   = proto_err_r;

  assign unused_d2h_s = ^{tl_i[D2H_OPCODE_LSB +: 3], tl_i[D2H_PARAM_LSB +: 3],
                          tl_i[D2H_SIZE_LSB +: TL_SZW], tl_i[D2H_SINK +: TL_DIW],
                          tl_i[D2H_USER_LSB +: TL_DUW]};

  prim_id_fifo #(
    .Depth (MaxReqs),
    .Width (IdxW),
    .CntW  (5)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (a_hs_s),
    .wdata  (idx_r),
    .pop    (pop_s),
    .head   (head_s),
    .full   (full_s),
    .empty  (empty_s),
    .count  (count_s)
  );

  // A-channel opcode selection from the write flag and byte enables.
  always_comb begin
    a_opcode_s = Get;
    if (!core.we_i) begin
      a_opcode_s = Get;
    end else if (core.be_i == 4'hf) begin
      a_opcode_s = PutFullData;
    end else begin
      a_opcode_s = PutPartialData;
    end
  end

  // Flattened A channel; d_ready is tied high since responses are never stalled.
  always_comb begin
    tl_o = {H2D_W{1'b0}};
    tl_o[H2D_A_VALID]                  = a_valid_s;
    tl_o[H2D_OPCODE_LSB +: 3]          = a_opcode_s;
    tl_o[H2D_PARAM_LSB +: 3]           = 3'h0;
    tl_o[H2D_SIZE_LSB +: TL_SZW]       = 2'd2;
    tl_o[H2D_SOURCE_LSB +: TL_AIW]     = a_source_s;
    tl_o[H2D_ADDR_LSB +: TL_AW]        = {core.addr_i[31:2], 2'b00};
    tl_o[H2D_MASK_LSB +: TL_DBW]       = core.we_i ? core.be_i : 4'hf;
    tl_o[H2D_DATA_LSB +: TL_DW]        = core.we_i ? core.wdata_i : 32'h0;
    tl_o[H2D_USER_LSB +: TL_DUW]       = 16'h0;
    tl_o[H2D_D_READY]                  = 1'b1;
  end

  // Core-side grant and response; a wrong source is reported as an error response.
  always_comb begin
    core.gnt_o    = a_hs_s;
    core.rvalid_o = pop_s;
    if (pop_s) begin
      core.rdata_o = tl_i[D2H_DATA_LSB +: TL_DW];
      core.err_o   = mismatch_s | tl_i[D2H_ERROR];
    end else begin
      core.rdata_o = 32'h0;
      core.err_o   = 1'b0;
    end
  end

  // Source index allocation and the sticky protocol-violation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_r       <= {IdxW{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      if (a_hs_s) begin
        idx_r <= (idx_r == LastIdx) ? {IdxW{1'b0}} : idx_r + IdxW'(1);
      end else begin
        idx_r <= idx_r;
      end
      if (mismatch_s || unexpected_s) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

endmodule
